// File: rtl/key_mode_ctrl.sv
// Push-button debouncer with short/long press decoding that drives the
// breathing-LED speed selector and breathing enable.
module key_mode_ctrl #(
  parameter logic [19:0] CNT_20MS = 20'd1_000_000,
  parameter logic [25:0] CNT_LONG = 26'd50_000_000,
  parameter logic [2:0]  MODE_NUM = 3'd4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_in,
  output logic       key_state,
  output logic       key_flag,
  output logic       key_release,
  output logic       key_long,
  output logic [1:0] mode,
  output logic       breath_en
);

  typedef enum logic [1:0] {
    IDLE,
    FILTER_DN,
    PRESSED,
    FILTER_UP
  } state_t;

  state_t      r_state;
  logic [1:0]  r_sync;
  logic [19:0] r_fcnt;
  logic [25:0] r_hcnt;
  logic        r_long_seen;
  logic        r_key_state;
  logic        r_key_flag;
  logic        r_key_rel;
  logic        r_key_long;
  logic [1:0]  r_mode;
  logic        r_breath;

  logic w_key;
  logic w_fdone;
  logic w_hmax;
  logic w_wrap;

  assign w_key   = r_sync[1];
  assign w_fdone = (r_fcnt == (CNT_20MS - 20'd1));
  assign w_hmax  = (r_hcnt == (CNT_LONG - 26'd1));
  assign w_wrap  = ({1'b0, r_mode} == (MODE_NUM - 3'd1));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_sync      <= 2'b11;
      r_state     <= IDLE;
      r_fcnt      <= '0;
      r_hcnt      <= '0;
      r_long_seen <= 1'b0;
      r_key_state <= 1'b0;
      r_key_flag  <= 1'b0;
      r_key_rel   <= 1'b0;
      r_key_long  <= 1'b0;
      r_mode      <= 2'd0;
      r_breath    <= 1'b1;
    end else begin
      r_sync     <= {r_sync[0], key_in};
      r_key_flag <= 1'b0;
      r_key_rel  <= 1'b0;
      r_key_long <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (!w_key) begin
            r_state <= FILTER_DN;
            r_fcnt  <= '0;
          end
        end
        FILTER_DN: begin
          if (w_key) begin
            r_state <= IDLE;
            r_fcnt  <= '0;
          end else if (w_fdone) begin
            r_state     <= PRESSED;
            r_fcnt      <= '0;
            r_key_flag  <= 1'b1;
            r_key_state <= 1'b1;
            r_hcnt      <= '0;
            r_long_seen <= 1'b0;
          end else begin
            r_fcnt <= r_fcnt + 20'd1;
          end
        end
        PRESSED: begin
          // Threshold check is independent of the exit so it still fires
          if (!w_hmax) begin
            r_hcnt <= r_hcnt + 26'd1;
          end else if (!r_long_seen) begin
            r_key_long  <= 1'b1;
            r_breath    <= ~r_breath;
            r_long_seen <= 1'b1;
          end
          if (w_key) begin
            r_state <= FILTER_UP;
            r_fcnt  <= '0;
          end
        end
        FILTER_UP: begin
          if (!w_key) begin
            r_state <= PRESSED;
            r_fcnt  <= '0;
          end else if (w_fdone) begin
            r_state     <= IDLE;
            r_fcnt      <= '0;
            r_key_rel   <= 1'b1;
            r_key_state <= 1'b0;
            if (!r_long_seen) begin
              r_mode <= w_wrap ? 2'd0 : r_mode + 2'd1;
            end
          end else begin
            r_fcnt <= r_fcnt + 20'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_fcnt  <= '0;
        end
      endcase
    end
  end

  assign key_state   = r_key_state;
  assign key_flag    = r_key_flag;
  assign key_release = r_key_rel;
  assign key_long    = r_key_long;
  assign mode        = r_mode;
  assign breath_en   = r_breath;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Directed bench for key_mode_ctrl with short filter/hold windows.
module tb_key_mode_ctrl;

  logic       sys_clk;
  logic       sys_rst;
  logic       key_in;
  logic       key_state;
  logic       key_flag;
  logic       key_release;
  logic       key_long;
  logic [1:0] mode;
  logic       breath_en;

  int n_vec;
  int n_err;
  int cyc;
  int flag_cnt, rel_cnt, long_cnt, st_cnt;
  int flag_cyc, rel_cyc, long_cyc;

  key_mode_ctrl #(
    .CNT_20MS(20'd10),
    .CNT_LONG(26'd50),
    .MODE_NUM(3'd4)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_flag   (key_flag),
    .key_release(key_release),
    .key_long   (key_long),
    .mode       (mode),
    .breath_en  (breath_en)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial cyc = 0;
  always @(posedge sys_clk) cyc = cyc + 1;

  always @(negedge sys_clk) begin
    if (key_flag === 1'b1) begin
      flag_cnt = flag_cnt + 1;
      flag_cyc = cyc;
    end
    if (key_release === 1'b1) begin
      rel_cnt = rel_cnt + 1;
      rel_cyc = cyc;
    end
    if (key_long === 1'b1) begin
      long_cnt = long_cnt + 1;
      long_cyc = cyc;
    end
    if (key_state === 1'b1) st_cnt = st_cnt + 1;
  end

  task automatic clr_mon();
    flag_cnt = 0; rel_cnt = 0; long_cnt = 0; st_cnt = 0;
    flag_cyc = -1; rel_cyc = -1; long_cyc = -1;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    key_in  = 1'b1;
    sys_rst = 1'b1;
    wait_clk(3);
    sys_rst = 1'b0;
    wait_clk(2);
    clr_mon();
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Press for n_low clocks, release, then idle for gap clocks
  task automatic press(input int n_low, input int gap,
                       output int t_fall, output int t_rise);
    key_in = 1'b0;
    t_fall = cyc;
    wait_clk(n_low);
    key_in = 1'b1;
    t_rise = cyc;
    wait_clk(gap);
  endtask

  task automatic test_reset();
    int tf, tr;
    key_in  = 1'b1;
    sys_rst = 1'b1;
    #2;
    n_vec++;
    if (key_state !== 1'b0 || key_flag !== 1'b0 || key_release !== 1'b0 ||
        key_long !== 1'b0) begin
      n_err++;
      $display("FAIL reset_pulses: got st%b fl%b rl%b lg%b expected all 0",
               key_state, key_flag, key_release, key_long);
    end
    n_vec++;
    if (mode !== 2'd0 || breath_en !== 1'b1) begin
      n_err++;
      $display("FAIL reset_levels: got mode=%0d br=%b expected mode=0 br=1",
               mode, breath_en);
    end
    do_reset();
  endtask

  task automatic test_short();
    int tf, tr;
    do_reset();
    key_in = 1'b0;
    tf = cyc;
    wait_clk(30);
    n_vec++;
    if (key_state !== 1'b1) begin
      n_err++;
      $display("FAIL short_state_hi: got %b expected 1", key_state);
    end
    key_in = 1'b1;
    tr = cyc;
    wait_clk(20);
    chk("short_flag_cnt", flag_cnt, 1);
    chk("short_flag_lat", flag_cyc - tf, 13);
    chk("short_rel_cnt", rel_cnt, 1);
    chk("short_rel_lat", rel_cyc - tr, 13);
    chk("short_mode", int'(mode), 1);
    chk("short_long_cnt", long_cnt, 0);
    chk("short_state_lo", int'(key_state), 0);
    chk("short_breath", int'(breath_en), 1);
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      key_in = 1'b0; wait_clk(5);
      key_in = 1'b1; wait_clk(3);
      key_in = 1'b0; wait_clk(6);
      key_in = 1'b1; wait_clk(5);
    end
    wait_clk(15);
    chk("bounce_flag_cnt", flag_cnt, 0);
    chk("bounce_state_cyc", st_cnt, 0);
    chk("bounce_rel_cnt", rel_cnt, 0);
    chk("bounce_mode", int'(mode), 0);
  endtask

  task automatic test_long();
    int tf, tr;
    do_reset();
    press(120, 20, tf, tr);
    chk("long_flag_cnt", flag_cnt, 1);
    chk("long_cnt", long_cnt, 1);
    chk("long_after_flag", long_cyc - flag_cyc, 50);
    chk("long_breath", int'(breath_en), 0);
    chk("long_rel_cnt", rel_cnt, 1);
    chk("long_rel_lat", rel_cyc - tr, 13);
    chk("long_mode", int'(mode), 0);
  endtask

  task automatic test_mode_wrap();
    int tf, tr;
    int exp_m [5] = '{1, 2, 3, 0, 1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      press(25, 20, tf, tr);
      chk($sformatf("wrap_mode_%0d", i), int'(mode), exp_m[i]);
    end
    chk("wrap_rel_cnt", rel_cnt, 5);
    chk("wrap_long_cnt", long_cnt, 0);
  endtask

  task automatic test_glitch_hold();
    int tf, tr;
    do_reset();
    key_in = 1'b0;
    tf = cyc;
    wait_clk(50);
    key_in = 1'b1;
    wait_clk(4);
    key_in = 1'b0;
    wait_clk(40);
    chk("glitch_rel_cnt", rel_cnt, 0);
    chk("glitch_flag_cnt", flag_cnt, 1);
    chk("glitch_state", int'(key_state), 1);
    chk("glitch_long_cnt", long_cnt, 1);
    chk("glitch_long_at", long_cyc - tf, 67);
    key_in = 1'b1;
    tr = cyc;
    wait_clk(20);
    chk("glitch_rel_lat", rel_cyc - tr, 13);
    chk("glitch_mode", int'(mode), 0);
    chk("glitch_breath", int'(breath_en), 0);
  endtask

  task automatic test_reset_mid();
    int tf, tr;
    do_reset();
    press(25, 20, tf, tr);
    press(25, 20, tf, tr);
    press(80, 20, tf, tr);
    chk("mid_pre_mode", int'(mode), 2);
    chk("mid_pre_breath", int'(breath_en), 0);
    key_in = 1'b0;
    wait_clk(43);
    chk("mid_pre_state", int'(key_state), 1);
    #3;
    sys_rst = 1'b1;
    #1;
    n_vec++;
    if (mode !== 2'd0 || breath_en !== 1'b1 || key_state !== 1'b0) begin
      n_err++;
      $display("FAIL mid_async: got mode=%0d br=%b st=%b expected 0 1 0",
               mode, breath_en, key_state);
    end
    key_in = 1'b1;
    wait_clk(3);
    clr_mon();
    sys_rst = 1'b0;
    wait_clk(30);
    chk("mid_post_flag", flag_cnt, 0);
    chk("mid_post_rel", rel_cnt, 0);
    chk("mid_post_long", long_cnt, 0);
    chk("mid_post_mode", int'(mode), 0);
    chk("mid_post_breath", int'(breath_en), 1);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    sys_rst = 1'b1;
    key_in  = 1'b1;
    clr_mon();
    wait_clk(1);
    test_reset();
    test_short();
    test_bounce();
    test_long();
    test_mode_wrap();
    test_glitch_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
